// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the state encoding (IDLE, FETCH, PRESENT, DRAIN and, with
// IFU_MISALIGN_CHECK_EN defined, HALT), the bubble encoding, the IF/ID
// payload struct and the target-alignment helper.
package instr_fetch_unit_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   // addi x0,x0,0
   localparam logic [ILEN-1:0] NOP_INSN_DEF = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP      = 64'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_PRESENT = 3'd2,
      ST_DRAIN   = 3'd3
`ifdef IFU_MISALIGN_CHECK_EN
      ,
      ST_HALT    = 3'd4
`endif
   } ifu_state_e;

   // What IF/ID sees: instruction, its PC, and whether it is real
   typedef struct packed {
      logic [ILEN-1:0] insn;
      logic [XLEN-1:0] pc;
      logic            valid;
   } ifid_payload_t;

   // Word-align a redirect target by clearing its two low bits
   function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
      return t & ~XLEN'(64'h3);
   endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-pc / next-imem_addr select for the fetch unit.
// Chooses between hold, sequential +4 and the branch target based on the
// current fetch state and this cycle's redirect / response / stall inputs.
// With IFU_MISALIGN_CHECK_EN defined the raw target is used and
// misalign_c_o flags a branch to a non-word-aligned address; otherwise the
// target is word-aligned here.
// Ports:
//   state_i          current fetch state
//   pc_i             next PC to be fetched (register value)
//   addr_i           current imem_addr register value
//   branch_taken_i   redirect pulse
//   branch_target_i  redirect address
//   pc_stall_i       hazard hold
//   rvalid_i         memory response valid
//   misalign_c_o     redirect to misaligned target (macro builds only)
//   pc_nxt_c_o       next value of the PC register
//   addr_nxt_c_o     next value of the imem_addr register
module ifu_next_pc
   import instr_fetch_unit_pkg::*;
(
   input  logic [2:0]      state_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] branch_target_i,
   input  logic            pc_stall_i,
   input  logic            rvalid_i,
`ifdef IFU_MISALIGN_CHECK_EN
   output logic            misalign_c_o,
`endif
   output logic [XLEN-1:0] pc_nxt_c_o,
   output logic [XLEN-1:0] addr_nxt_c_o
);

   logic [XLEN-1:0] tgt;
   logic [XLEN-1:0] seq_pc;
   logic            bad_tgt;
   ifu_state_e      state;

   assign state  = ifu_state_e'(state_i);
   // Modulo-2^64 increment; FFFF_FFFF_FFFF_FFFC wraps to 0
   assign seq_pc = addr_i + PC_STEP;

`ifdef IFU_MISALIGN_CHECK_EN
   assign tgt          = branch_target_i;
   assign bad_tgt      = branch_taken_i && (branch_target_i[1:0] != 2'b00);
   assign misalign_c_o = bad_tgt;
`else
   assign tgt     = align_target(branch_target_i);
   assign bad_tgt = 1'b0;
`endif

   // Select next pc / request address
   always_comb begin
      pc_nxt_c_o   = pc_i;
      addr_nxt_c_o = addr_i;
      if (branch_taken_i) begin
         pc_nxt_c_o = tgt;
         // A misaligned redirect halts; keep the last address on the bus
         if (!bad_tgt) begin
            case (state)
               ST_IDLE, ST_PRESENT: addr_nxt_c_o = tgt;
               // Outstanding request must keep its address until answered
               ST_FETCH, ST_DRAIN:  if (rvalid_i) addr_nxt_c_o = tgt;
               default:             addr_nxt_c_o = addr_i;
            endcase
         end
      end else begin
         case (state)
            ST_IDLE:    addr_nxt_c_o = pc_i;
            ST_FETCH:   if (rvalid_i) pc_nxt_c_o = seq_pc;
            ST_PRESENT: if (!pc_stall_i) addr_nxt_c_o = pc_i;
            ST_DRAIN:   if (rvalid_i) addr_nxt_c_o = pc_i;
            default:    addr_nxt_c_o = addr_i;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV64 fetch stage feeding the IF/ID register.
// Owns the PC, issues one outstanding request at a time to a variable
// latency instruction memory and presents either a fetched instruction or
// a NOP bubble. A taken branch redirects fetch, discards any in-flight
// response and raises if_flush combinationally.
// Optional feature macro: IFU_MISALIGN_CHECK_EN -- when defined, a branch to
// a non-word-aligned target sets the sticky fetch_misalign flag and halts
// fetch until reset; when undefined, targets are word-aligned and
// fetch_misalign is tied 0.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   pc_stall            hold presented instruction and PC
//   branch_taken        1-cycle redirect pulse from EX
//   branch_target       redirect address
//   imem_req/imem_addr  request handshake to instruction memory
//   imem_rvalid/rdata   memory response
//   Instruction/PC_Out  to IF/ID
//   fetch_valid         Instruction is real (not a bubble)
//   if_flush            IF/ID flush, equal to branch_taken
//   fetch_misalign      sticky misaligned-target flag
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0,
   parameter logic [ILEN-1:0] NOP_INSN = NOP_INSN_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pc_stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic [ILEN-1:0] Instruction,
   output logic [XLEN-1:0] PC_Out,
   output logic            fetch_valid,
   output logic            if_flush,
   output logic            fetch_misalign
);

   ifu_state_e      state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] addr_q;
   ifid_payload_t   out_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] addr_d;

`ifdef IFU_MISALIGN_CHECK_EN
   logic misalign_q;
   logic pend_q;     // a request was still in flight when HALT was entered
   logic misalign_c;
`endif

   ifu_next_pc u_next_pc (
      .state_i         (3'(state_q)),
      .pc_i            (pc_q),
      .addr_i          (addr_q),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .pc_stall_i      (pc_stall),
      .rvalid_i        (imem_rvalid),
`ifdef IFU_MISALIGN_CHECK_EN
      .misalign_c_o    (misalign_c),
`endif
      .pc_nxt_c_o      (pc_d),
      .addr_nxt_c_o    (addr_d)
   );

   // Fetch FSM with registered IF/ID outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         out_q   <= '{insn: NOP_INSN, pc: '0, valid: 1'b0};
`ifdef IFU_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
         pend_q     <= 1'b0;
`endif
      end else begin
         pc_q   <= pc_d;
         addr_q <= addr_d;
`ifdef IFU_MISALIGN_CHECK_EN
         if (state_q == ST_HALT) begin
            // Only retire the pending response; nothing new is issued
            if (imem_rvalid) pend_q <= 1'b0;
         end else if (misalign_c) begin
            out_q.insn  <= NOP_INSN;
            out_q.valid <= 1'b0;
            misalign_q  <= 1'b1;
            pend_q      <= ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) && !imem_rvalid;
            state_q     <= ST_HALT;
         end else
`endif
         if (branch_taken) begin
            // Redirect wins over stall and response in every state
            out_q.insn  <= NOP_INSN;
            out_q.valid <= 1'b0;
            case (state_q)
               ST_FETCH, ST_DRAIN:  state_q <= imem_rvalid ? ST_FETCH : ST_DRAIN;
               ST_IDLE, ST_PRESENT: state_q <= ST_FETCH;
               default:             state_q <= state_q;
            endcase
         end else begin
            case (state_q)
               ST_IDLE: state_q <= ST_FETCH;
               ST_FETCH: begin
                  if (imem_rvalid) begin
                     out_q   <= '{insn: imem_rdata, pc: addr_q, valid: 1'b1};
                     state_q <= ST_PRESENT;
                  end
               end
               ST_PRESENT: begin
                  // IF/ID captures on this edge unless stalled
                  if (!pc_stall) begin
                     out_q.insn  <= NOP_INSN;
                     out_q.valid <= 1'b0;
                     state_q     <= ST_FETCH;
                  end
               end
               ST_DRAIN: if (imem_rvalid) state_q <= ST_FETCH;
               default:  state_q <= state_q;
            endcase
         end
      end
   end

`ifdef IFU_MISALIGN_CHECK_EN
   assign imem_req       = (state_q == ST_FETCH) || (state_q == ST_DRAIN) ||
                           ((state_q == ST_HALT) && pend_q);
   assign fetch_misalign = misalign_q;
`else
   assign imem_req       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign fetch_misalign = 1'b0;
`endif

   assign imem_addr   = addr_q;
   assign Instruction = out_q.insn;
   assign PC_Out      = out_q.pc;
   assign fetch_valid = out_q.valid;
   assign if_flush    = branch_taken;

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   localparam logic [63:0] RESET_PC = 64'h0;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pc_stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [63:0] branch_target = '0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] Instruction;
   logic [63:0] PC_Out;
   logic        fetch_valid;
   logic        if_flush;
   logic        fetch_misalign;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSN(NOP)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_stall       (pc_stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .Instruction    (Instruction),
      .PC_Out         (PC_Out),
      .fetch_valid    (fetch_valid),
      .if_flush       (if_flush),
      .fetch_misalign (fetch_misalign)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] insn;
   } exp_t;
   exp_t exp_q[$];

   // Reference program-flow model
   logic [63:0] model_pc;
   bit          halted = 1'b0;

   // Memory responder state
   bit          busy = 1'b0;
   int          cnt = 0;
   logic [63:0] req_addr = '0;
   int unsigned lat_min = 1, lat_max = 1;
   int unsigned p_stall = 0, p_branch = 0;
   bit          force_stall = 1'b0;
   bit          br_on_new_req = 1'b0, br_on_resp = 1'b0;
   logic [63:0] force_tgt = '0;
   bit          chk_req = 1'b0;
   logic [63:0] chk_req_addr = '0;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5677;
   endfunction

   function automatic logic [63:0] fetch_target(input logic [63:0] t);
`ifdef IFU_MISALIGN_CHECK_EN
      return t;
`else
      return {t[63:2], 2'b00};
`endif
   endfunction

   function automatic void expect_at(input logic [63:0] a);
      exp_q.push_back('{pc: a, insn: mem_word(a)});
      model_pc = a;
   endfunction

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: memory responder, stall/branch drive, model update
   task automatic step();
      bit br, st, forced;
      logic [63:0] tgt;
      @(negedge clk);
      br = 1'b0;
      forced = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (busy) begin
         check64("req_held", 64'(imem_req), 64'd1);
         check64("addr_stable", imem_addr, req_addr);
      end else if (imem_req) begin
         busy = 1'b1;
         req_addr = imem_addr;
         cnt = int'($urandom_range(lat_max - 1, lat_min - 1));
         if (chk_req) begin
            check64("redirect_addr", imem_addr, chk_req_addr);
            chk_req = 1'b0;
         end
         if (br_on_new_req) begin
            br = 1'b1; forced = 1'b1; br_on_new_req = 1'b0;
         end
      end
      if (busy) begin
         if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(req_addr);
            busy = 1'b0;
            if (br_on_resp) begin
               br = 1'b1; forced = 1'b1; br_on_resp = 1'b0;
            end
         end else begin
            cnt--;
         end
      end
      st = force_stall || ($urandom_range(99, 0) < p_stall);
      if (!br) br = ($urandom_range(99, 0) < p_branch);
      tgt = forced ? force_tgt : ({$urandom, $urandom} & ~64'h3);
      pc_stall      = st;
      branch_taken  = br;
      branch_target = tgt;
      if (!halted) begin
         if (br) begin
            exp_q.delete();
`ifdef IFU_MISALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) halted = 1'b1;
            else
`endif
            begin
               expect_at(fetch_target(tgt));
               if (forced) begin
                  chk_req = 1'b1;
                  chk_req_addr = fetch_target(tgt);
               end
            end
         end else if (fetch_valid && !st) begin
            expect_at(model_pc + 64'd4);
         end
      end
      #1;
      check64("if_flush", 64'(if_flush), 64'(br));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_busy();
      int n;
      n = 0;
      while (!busy && n < 50) begin
         step();
         n++;
      end
      check64("wait_busy", 64'(busy), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      pc_stall = 1'b0; branch_taken = 1'b0; imem_rvalid = 1'b0;
      busy = 1'b0; chk_req = 1'b0; halted = 1'b0;
      br_on_new_req = 1'b0; br_on_resp = 1'b0; force_stall = 1'b0;
      exp_q.delete();
      #3;
      check64("rst_instruction", 64'(Instruction), 64'(NOP));
      check64("rst_pc_out", PC_Out, 64'd0);
      check64("rst_fetch_valid", 64'(fetch_valid), 64'd0);
      check64("rst_imem_addr", imem_addr, RESET_PC);
      check64("rst_imem_req", 64'(imem_req), 64'd0);
      check64("rst_misalign", 64'(fetch_misalign), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      expect_at(RESET_PC);
   endtask

   // Monitor: compares presented instructions against the expectation queue
   initial begin
      logic        prev_v;
      logic [31:0] prev_i;
      logic [63:0] prev_p;
      int          idle;
      exp_t        e;
      prev_v = 1'b0; prev_i = '0; prev_p = '0; idle = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            prev_v = 1'b0;
            idle = 0;
         end else begin
            check64("misalign_flag", 64'(fetch_misalign), 64'(halted));
            if (fetch_valid) begin
               check64("req_low_in_present", 64'(imem_req), 64'd0);
               if (!prev_v) begin
                  idle = 0;
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_fetch: got pc %h, none expected", PC_Out);
                  end else begin
                     e = exp_q.pop_front();
                     check64("pc_out", PC_Out, e.pc);
                     check64("instruction", 64'(Instruction), 64'(e.insn));
                  end
               end else begin
                  check64("stall_hold_insn", 64'(Instruction), 64'(prev_i));
                  check64("stall_hold_pc", PC_Out, prev_p);
               end
            end else begin
               check64("bubble_nop", 64'(Instruction), 64'(NOP));
               if (exp_q.size() != 0) idle++;
               else idle = 0;
               if (idle > 100) begin
                  checks++;
                  errors++;
                  $display("FAIL fetch_timeout: got no instruction for %0d cycles, expected pc %h", idle, exp_q[0].pc);
                  idle = 0;
               end
            end
            prev_v = fetch_valid;
            prev_i = Instruction;
            prev_p = PC_Out;
         end
      end
   end

   initial begin
      // Sequential fetch, latency 1: 0, 4, 8, ...
      do_reset();
      run(20);

      // Long stall while presenting
      force_stall = 1'b1;
      run(12);
      force_stall = 1'b0;
      run(6);

      // Redirect while a latency-3 fetch is outstanding
      lat_min = 3; lat_max = 3;
      for (int k = 0; k < 3; k++) begin
         force_tgt = 64'h100;
         br_on_new_req = 1'b1;
         run(20);
      end

      // Redirect coinciding with the response
      for (int k = 0; k < 3; k++) begin
         force_tgt = 64'h200 + 64'(k) * 64'h40;
         br_on_resp = 1'b1;
         run(20);
      end

      // PC wrap at top of address space
      lat_min = 1; lat_max = 2;
      force_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
      br_on_new_req = 1'b1;
      run(20);

      // Randomized traffic
      lat_min = 1; lat_max = 4; p_stall = 30; p_branch = 8;
      run(3000);
      p_stall = 0; p_branch = 0;
      run(20);

      // Reset in the middle of an outstanding request
      lat_min = 3; lat_max = 3;
      wait_busy();
      do_reset();
      run(20);

      // Misaligned redirect target
      force_tgt = 64'h102;
      br_on_new_req = 1'b1;
      run(30);
`ifdef IFU_MISALIGN_CHECK_EN
      check64("halt_misalign", 64'(fetch_misalign), 64'd1);
      check64("halt_req", 64'(imem_req), 64'd0);
      check64("halt_valid", 64'(fetch_valid), 64'd0);
      check64("halt_insn", 64'(Instruction), 64'(NOP));
`endif
      do_reset();
      run(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
